nibble_fifo4: RTL and testbench

Downstream buffering stage for the 4-bit mux-and-double-register datapath: it captures each registered nibble the pipeline presents, holds up to DEPTH entries, and releases them to a consumer through a valid/ready handshake. It decouples the free-running mux pipeline from a consumer that may stall. Its overflow flag reports any nibble the pipeline offered while the buffer was full, so those drops are detected rather than silent.

---
 rtl/nibble_fifo4_if.sv | 40 ++++
 rtl/nibble_fifo4.sv | 64 ++++++
 tb/tb_nibble_fifo4.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nibble_fifo4_if.sv
// Handshake bundle between the mux pipeline, nibble_fifo4 and its consumer.
// The count signal exists only when NIBBLE_FIFO_COUNT_EN is defined.
interface nibble_fifo4_if #(
    parameter int WIDTH = 4
`ifdef NIBBLE_FIFO_COUNT_EN
    ,
    parameter int DEPTH = 4
`endif
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             full;
    logic             empty;
    logic             overflow;
`ifdef NIBBLE_FIFO_COUNT_EN
    logic [$clog2(DEPTH):0] count;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, full, empty, overflow, count
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, full, empty, overflow, count
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, full, empty, overflow
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, full, empty, overflow
    );
`endif
endinterface

// File: rtl/nibble_fifo4.sv
// First-word-fall-through nibble buffer with sticky overflow flag.
// Defining NIBBLE_FIFO_COUNT_EN adds the occupancy output bus.count.
module nibble_fifo4 #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    nibble_fifo4_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             overflow;

    // The extra pointer MSB tells a full buffer apart from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (bus.in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = overflow;

`ifdef NIBBLE_FIFO_COUNT_EN
    assign bus.count = wr_ptr - rd_ptr;
`endif
endmodule

// File: tb/tb_nibble_fifo4.sv
// Self-checking bench for nibble_fifo4 against a queue-based reference model.
// Count comparisons are compiled in only with NIBBLE_FIFO_COUNT_EN.
module tb_nibble_fifo4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [3:0] model_q[$];
    logic       model_ovf = 1'b0;

    nibble_fifo4_if bus ();

    nibble_fifo4 #(.DEPTH(DEPTH), .WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_data();
        return (model_q.size() != 0) ? model_q[0] : 4'h0;
    endfunction

    // Drive one cycle, advance the reference model across the edge, settle 1ns past it.
    task automatic step(input logic v, input logic [3:0] d, input logic r, input logic rs);
        bit was_full;
        bit was_empty;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        rst           = rs;
        @(posedge clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (rs) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (r && !was_empty) void'(model_q.pop_front());
            if (v && !was_full) model_q.push_back(d);
            if (v && was_full) model_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty); end
        vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        vectors++; if (bus.out_data !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %h expected 0", bus.out_data); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
`ifdef NIBBLE_FIFO_COUNT_EN
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
`endif
    endtask

    task automatic test_fill_drain();
        logic [3:0] pattern [4];
        pattern = '{4'h3, 4'h9, 4'hC, 4'h5};
        for (int i = 0; i < 4; i++) step(1'b1, pattern[i], 1'b0, 1'b0);
        vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_full: got %b expected 1", bus.full); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
`ifdef NIBBLE_FIFO_COUNT_EN
        vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("[TB] FAIL fill_count: got %0d expected 4", bus.count); end
`endif
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.out_data !== pattern[i] || bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_data[%0d]: got %h/v%b expected %h/v1", i, bus.out_data, bus.out_valid, pattern[i]); end
            step(1'b0, 4'h0, 1'b1, 1'b0);
        end
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) step(1'b1, 4'($urandom_range(0, 14)), 1'b0, 1'b0);
        step(1'b1, 4'hF, 1'b1, 1'b0);
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_set: got %b expected 1", bus.overflow); end
        step(1'b0, 4'h0, 1'b0, 1'b0);
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_sticky: got %b expected 1", bus.overflow); end
        for (int i = 0; i < 6; i++) begin
            vectors++; if (bus.out_data !== exp_data() || bus.out_data === 4'hF) begin miscompares++; $display("[TB] FAIL overflow_drain[%0d]: got %h expected %h", i, bus.out_data, exp_data()); end
            step(1'b0, 4'h0, 1'b1, 1'b0);
        end
        vectors++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_after_drain: got empty=%b ovf=%b expected empty=1 ovf=1", bus.empty, bus.overflow); end
        step(1'b0, 4'h0, 1'b0, 1'b1);
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL overflow_cleared: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 4'hE, 1'b0, 1'b0);
        step(1'b1, 4'hD, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            vectors++; if (bus.out_data !== exp_data()) begin miscompares++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, bus.out_data, exp_data()); end
            step(1'b1, 4'(i), 1'b1, 1'b0);
`ifdef NIBBLE_FIFO_COUNT_EN
            vectors++; if (bus.count !== 3'd2) begin miscompares++; $display("[TB] FAIL b2b_count[%0d]: got %0d expected 2", i, bus.count); end
`endif
        end
        vectors++; if (bus.out_data !== 4'h9) begin miscompares++; $display("[TB] FAIL b2b_head: got %h expected 9", bus.out_data); end
        step(1'b0, 4'h0, 1'b1, 1'b0);
        vectors++; if (bus.out_data !== 4'hA) begin miscompares++; $display("[TB] FAIL b2b_tail: got %h expected a", bus.out_data); end
        step(1'b0, 4'h0, 1'b1, 1'b0);
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_push_empty();
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h7;
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL pe_no_bypass: got %b expected 0", bus.out_valid); end
        step(1'b1, 4'h7, 1'b1, 1'b0);
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h7) begin miscompares++; $display("[TB] FAIL pe_visible: got %h/v%b expected 7/v1", bus.out_data, bus.out_valid); end
        step(1'b0, 4'h0, 1'b1, 1'b0);
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL pe_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 4), 1'b0, 1'b0);
        step(1'b1, 4'h8, 1'b1, 1'b1);
        vectors++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset: got empty=%b ovf=%b expected empty=1 ovf=0", bus.empty, bus.overflow); end
`ifdef NIBBLE_FIFO_COUNT_EN
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", bus.count); end
`endif
        step(1'b1, 4'h2, 1'b0, 1'b0);
        vectors++; if (bus.out_data !== 4'h2 || bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_first: got %h/v%b expected 2/v1", bus.out_data, bus.out_valid); end
        step(1'b0, 4'h0, 1'b1, 1'b0);
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_only_entry: got empty=%b expected 1", bus.empty); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 49) == 0));
            vectors++; if (bus.out_data !== exp_data()) begin miscompares++; $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", i, bus.out_data, exp_data()); end
            vectors++; if (bus.out_valid !== (model_q.size() != 0) || bus.empty !== (model_q.size() == 0)) begin miscompares++; $display("[TB] FAIL rnd_empty[%0d]: got v%b e%b expected size %0d", i, bus.out_valid, bus.empty, model_q.size()); end
            vectors++; if (bus.full !== (model_q.size() == DEPTH) || bus.in_ready !== (model_q.size() != DEPTH)) begin miscompares++; $display("[TB] FAIL rnd_full[%0d]: got f%b r%b expected size %0d", i, bus.full, bus.in_ready, model_q.size()); end
            vectors++; if (bus.overflow !== model_ovf) begin miscompares++; $display("[TB] FAIL rnd_overflow[%0d]: got %b expected %b", i, bus.overflow, model_ovf); end
`ifdef NIBBLE_FIFO_COUNT_EN
            vectors++; if (bus.count !== 3'(model_q.size())) begin miscompares++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, bus.count, model_q.size()); end
`endif
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_back_to_back();
        test_push_empty();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
